// File: rtl/seg7_scan_driver.sv
// ============================================================================
// Module      : seg7_scan_driver
// Description : Multiplexed hex 7-segment driver with dead time, per-digit dp
//               and blanking, and frame-aligned commit of new display values.
//               Optional feature macro: SEG7_LZB_EN (leading-zero blanking).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 50000,
  parameter int DEADTIME       = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  output logic                  pending,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     dig,
  output logic                  frame_done
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);

  localparam logic [CNT_W-1:0]  c_cnt_max = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  c_dead    = CNT_W'(DEADTIME);
  localparam logic [IDX_W-1:0]  c_idx_max = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        c_seg_off = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              c_dp_off  = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] c_dig_off = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] sh_data_q, sh_data_d, disp_data_q, disp_data_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]   sh_blank_q, sh_blank_d, disp_blank_q, disp_blank_d;
  logic                pending_q, pending_d;
  logic                frame_done_q, frame_done_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   dig_q, dig_d;

  logic                w_slot_end, w_frame_end, w_on;
  logic [3:0]          w_nib;
  logic                w_dp_sel, w_blank_sel, w_all_zero;
  logic [DIGITS-1:0]   w_lzb, w_dig_hi;
  logic [6:0]          w_seg_hi;
  logic                w_dp_hi;

  // Scan counters and the shadow/display commit path.
  always_comb begin
    w_slot_end   = (cnt_q == c_cnt_max);
    w_frame_end  = w_slot_end && (idx_q == c_idx_max);
    cnt_d        = w_slot_end ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    if (w_slot_end) idx_d = (idx_q == c_idx_max) ? '0 : idx_q + 1'b1;
    frame_done_d = w_frame_end;

    sh_data_d    = sh_data_q;
    sh_dp_d      = sh_dp_q;
    sh_blank_d   = sh_blank_q;
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    pending_d    = pending_q;

    if (load) begin
      sh_data_d  = data;
      sh_dp_d    = dp_in;
      sh_blank_d = blank_in;
    end

    if (w_frame_end) begin
      if (load) begin
        disp_data_d  = data;
        disp_dp_d    = dp_in;
        disp_blank_d = blank_in;
        pending_d    = 1'b0;
      end else if (pending_q) begin
        disp_data_d  = sh_data_q;
        disp_dp_d    = sh_dp_q;
        disp_blank_d = sh_blank_q;
        pending_d    = 1'b0;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  // A digit is LZB-dark when it and every digit to its left hold zero.
  always_comb begin
    w_lzb      = '0;
    w_all_zero = 1'b1;
`ifdef SEG7_LZB_EN
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_all_zero = w_all_zero && (disp_data_q[4*i +: 4] == 4'h0);
      w_lzb[i]   = w_all_zero;
    end
`endif
  end

  // Output stage: decode the currently scanned digit, then apply polarity.
  always_comb begin
    w_nib       = 4'h0;
    w_dp_sel    = 1'b0;
    w_blank_sel = 1'b0;
    w_dig_hi    = '0;
    w_on        = (cnt_q >= c_dead);
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        w_nib       = disp_data_q[4*i +: 4];
        w_dp_sel    = disp_dp_q[i];
        w_blank_sel = disp_blank_q[i] | w_lzb[i];
        w_dig_hi[i] = w_on;
      end
    end
    w_seg_hi = (w_on && !w_blank_sel) ? f_decode(w_nib) : 7'h00;
    w_dp_hi  = w_on && !w_blank_sel && w_dp_sel;
    seg_d    = (SEG_ACTIVE_LOW != 0) ? ~w_seg_hi : w_seg_hi;
    dp_d     = (SEG_ACTIVE_LOW != 0) ? ~w_dp_hi  : w_dp_hi;
    dig_d    = (DIG_ACTIVE_LOW != 0) ? ~w_dig_hi : w_dig_hi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= c_seg_off;
      dp_q         <= c_dp_off;
      dig_q        <= c_dig_off;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sh_data_q    <= sh_data_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_q        <= dig_d;
    end
  end

  assign pending    = pending_q;
  assign frame_done = frame_done_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign dig        = dig_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Scoreboard bench for seg7_scan_driver (4 digits, 4-cycle slot).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

  localparam int DIGITS   = 4;
  localparam int CLK_DIV  = 4;
  localparam int DEADTIME = 1;
  localparam int FRAME    = CLK_DIV * DIGITS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank_in = 4'h0;
  logic        pending;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig;
  logic        frame_done;

  seg7_scan_driver #(
    .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .DEADTIME(DEADTIME),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data), .dp_in(dp_in),
    .blank_in(blank_in), .pending(pending), .seg(seg), .dp(dp), .dig(dig),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic       pend;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: position = clock edges since reset, plus frame-level values.
  int         pos;
  logic [3:0] m_nib [4];
  logic       m_dpv [4];
  logic       m_blk [4];
  logic [3:0] s_nib [4];
  logic       s_dpv [4];
  logic       s_blk [4];
  logic       m_pend;
  logic       m_wrap;
  obs_t       m_obs;
  obs_t       mon_e, mon_a;

  function automatic logic lz_dark(input int d);
`ifdef SEG7_LZB_EN
    if (d == 0) return 1'b0;
    for (int j = d; j < DIGITS; j++) if (m_nib[j] != 4'h0) return 1'b0;
    return 1'b1;
`else
    return (d < 0);
`endif
  endfunction

  function automatic obs_t predict(input int p, input logic fd);
    obs_t o;
    int   c, d;
    c = p % CLK_DIV;
    d = (p / CLK_DIV) % DIGITS;
    o = '{dig: 4'hF, seg: 7'h7F, dp: 1'b1, fd: fd, pend: 1'b0};
    if (c >= DEADTIME) begin
      o.dig = 4'hF & ~(4'b0001 << d);
      if (!m_blk[d] && !lz_dark(d)) begin
        o.seg = ~dec_tab[m_nib[d]];
        o.dp  = ~m_dpv[d];
      end
    end
    return o;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos    = 0;
      m_pend = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_nib[i] = 4'h0; m_dpv[i] = 1'b0; m_blk[i] = 1'b0;
        s_nib[i] = 4'h0; s_dpv[i] = 1'b0; s_blk[i] = 1'b0;
      end
      exp_q.delete();
      exp_q.push_back('{dig: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0, pend: 1'b0});
    end else begin
      m_wrap = ((pos + 1) % FRAME) == 0;
      m_obs  = predict(pos, m_wrap);
      if (load) begin
        for (int i = 0; i < 4; i++) begin
          s_nib[i] = data[4*i +: 4]; s_dpv[i] = dp_in[i]; s_blk[i] = blank_in[i];
        end
      end
      if (m_wrap && (load || m_pend)) begin
        for (int i = 0; i < 4; i++) begin
          m_nib[i] = s_nib[i]; m_dpv[i] = s_dpv[i]; m_blk[i] = s_blk[i];
        end
        m_pend = 1'b0;
      end else if (load) begin
        m_pend = 1'b1;
      end
      m_obs.pend = m_pend;
      exp_q.push_back(m_obs);
      pos = pos + 1;
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = '{dig: dig, seg: seg, dp: dp, fd: frame_done, pend: pending};
      checks++;
      if (mon_a !== mon_e) begin
        failures++;
        $display("FAIL scan t=%0t act dig=%b seg=%h dp=%b fd=%b pend=%b req dig=%b seg=%h dp=%b fd=%b pend=%b",
                 $time, mon_a.dig, mon_a.seg, mon_a.dp, mon_a.fd, mon_a.pend,
                 mon_e.dig, mon_e.seg, mon_e.dp, mon_e.fd, mon_e.pend);
      end
    end
  end

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bl);
    data = d; dp_in = dpv; blank_in = bl; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Waits (at most one frame) until the next edge is at the given frame phase.
  task automatic load_at(input int phase, input logic [15:0] d, input logic [3:0] dpv,
                         input logic [3:0] bl);
    @(negedge clk);
    for (int n = 0; n < FRAME && (pos % FRAME) != phase; n++) @(negedge clk);
    pulse_load(d, dpv, bl);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    load_at(5, 16'h1A5F, 4'h0, 4'h0);
    repeat (40) @(negedge clk);
    load_at(2, 16'h1111, 4'h0, 4'h0);
    load_at(8, 16'h2222, 4'h0, 4'h0);
    repeat (40) @(negedge clk);
    load_at(15, 16'h3C7E, 4'b1010, 4'h0);
    repeat (20) @(negedge clk);
    load_at(3, 16'h4321, 4'b0001, 4'b0100);
    repeat (40) @(negedge clk);
    load_at(9, 16'h0050, 4'h0, 4'h0);
    repeat (40) @(negedge clk);

    for (int k = 0; k < 60; k++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      if ($urandom_range(0, 3) == 0)
        load_at(15, 16'($urandom), 4'($urandom), 4'($urandom_range(0, 1) != 0 ? $urandom : 0));
      else
        pulse_load(16'($urandom), 4'($urandom), 4'($urandom_range(0, 1) != 0 ? $urandom : 0));
    end
    repeat (30) @(negedge clk);

    // Asynchronous reset in the middle of a lit slot.
    for (int n = 0; n < FRAME && (pos % CLK_DIV) != 2; n++) @(negedge clk);
    pulse_load(16'h8888, 4'hF, 4'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dig, seg, dp, frame_done, pending} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset act dig=%b seg=%h dp=%b fd=%b pend=%b req dig=1111 seg=7f dp=1 fd=0 pend=0",
               dig, seg, dp, frame_done, pending);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    pulse_load(16'h9ABC, 4'b0110, 4'b0000);
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
